vm1_qbus_master: RTL and testbench



---
 rtl/vm1_qbus_master.sv | 233 +++++++++++++++++++++++
 tb/tb_vm1_qbus_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vm1_qbus_master.sv
// Q-bus master for the 1801VM1 core: sequences SYNC/DIN/DOUT bus cycles with
// setup, reply wait with timeout, release, reply-less SEL1/SEL2 windows and
// DMA arbitration. All state advances only on clock-enabled ticks.
module vm1_qbus_master #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       TO_W      = 6,
  parameter int unsigned       TIMEOUT   = 63,
  parameter int unsigned       SETUP     = 1,
  parameter logic [ADDR_W-1:0] SEL1_ADDR = 16'o177716,
  parameter logic [ADDR_W-1:0] SEL2_ADDR = 16'o177714
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              req_i,
  input  logic              we_i,
  input  logic              byte_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] ad_o,
  input  logic [DATA_W-1:0] ad_i,
  output logic              sync_o,
  output logic              din_o,
  output logic              dout_o,
  output logic              wtbt_o,
  input  logic              rply_i,
  output logic              bsy_o,
  output logic              sel1_o,
  output logic              sel2_o,
  input  logic              dmr_i,
  output logic              dmgo_o,
  input  logic              sack_i
);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StRelease, StGrant, StDma} state_e;

  state_e              r_state, w_state_nxt;
  logic [TO_W-1:0]     r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_we, w_we_nxt;
  logic                r_byte, w_byte_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic [ADDR_W-1:0]   r_ad, w_ad_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;
  logic                r_errp, w_errp_nxt;
  logic                r_sync, w_sync_nxt;
  logic                r_din, w_din_nxt;
  logic                r_dout, w_dout_nxt;
  logic                r_wtbt, w_wtbt_nxt;
  logic                r_sel1, w_sel1_nxt;
  logic                r_sel2, w_sel2_nxt;
  logic                r_dmgo, w_dmgo_nxt;

  logic w_hit1, w_hit2;

  // Reply-less windows compare the word address only.
  assign w_hit1 = (r_addr[ADDR_W-1:1] == SEL1_ADDR[ADDR_W-1:1]);
  assign w_hit2 = (r_addr[ADDR_W-1:1] == SEL2_ADDR[ADDR_W-1:1]);

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ad    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_errp  <= 1'b0;
      r_sync  <= 1'b0;
      r_din   <= 1'b0;
      r_dout  <= 1'b0;
      r_wtbt  <= 1'b0;
      r_sel1  <= 1'b0;
      r_sel2  <= 1'b0;
      r_dmgo  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_we    <= w_we_nxt;
      r_byte  <= w_byte_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
      r_ad    <= w_ad_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_errp  <= w_errp_nxt;
      r_sync  <= w_sync_nxt;
      r_din   <= w_din_nxt;
      r_dout  <= w_dout_nxt;
      r_wtbt  <= w_wtbt_nxt;
      r_sel1  <= w_sel1_nxt;
      r_sel2  <= w_sel2_nxt;
      r_dmgo  <= w_dmgo_nxt;
    end
  end

  // Next-state and registered-output logic for the bus cycle sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_we_nxt    = r_we;
    w_byte_nxt  = r_byte;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_ad_nxt    = r_ad;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_errp_nxt  = r_errp;
    w_sync_nxt  = r_sync;
    w_din_nxt   = r_din;
    w_dout_nxt  = r_dout;
    w_wtbt_nxt  = r_wtbt;
    w_sel1_nxt  = r_sel1;
    w_sel2_nxt  = r_sel2;
    w_dmgo_nxt  = r_dmgo;
    if (ce) begin
      w_done_nxt = 1'b0;
      w_err_nxt  = 1'b0;
      unique case (r_state)
        StIdle: begin
          if (dmr_i) begin
            w_state_nxt = StGrant;
            w_dmgo_nxt  = 1'b1;
          end else if (req_i && !r_err) begin
            // r_err guard: a request still high in the tick after an odd-address
            // error must not be taken as a new access.
            if (!byte_i && addr_i[0]) begin
              w_err_nxt = 1'b1;
            end else begin
              w_state_nxt = StAddr;
              w_addr_nxt  = addr_i;
              w_we_nxt    = we_i;
              w_byte_nxt  = byte_i;
              w_wdata_nxt = wdata_i;
              w_sync_nxt  = 1'b1;
              w_ad_nxt    = addr_i;
              w_wtbt_nxt  = we_i;
              w_cnt_nxt   = TO_W'(SETUP - 1);
            end
          end
        end
        StAddr: begin
          if (r_cnt == '0) begin
            w_state_nxt = StData;
            w_din_nxt   = ~r_we;
            w_dout_nxt  = r_we;
            w_wtbt_nxt  = r_byte;
            w_ad_nxt    = r_we ? ADDR_W'(r_wdata) : '0;
            w_cnt_nxt   = TO_W'(TIMEOUT);
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        StData: begin
          if (r_sel1 || r_sel2 || (!w_hit1 && !w_hit2 && rply_i)) begin
            w_done_nxt = 1'b1;
            if (!r_we) w_rdata_nxt = ad_i;
            w_state_nxt = StRelease;
          end else if (w_hit1) begin
            w_sel1_nxt = 1'b1;
          end else if (w_hit2) begin
            w_sel2_nxt = 1'b1;
          end else if (r_cnt == '0) begin
            w_err_nxt   = 1'b1;
            w_errp_nxt  = 1'b1;
            w_state_nxt = StRelease;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
          // Any exit from the data phase drops the strobes but keeps SYNC.
          if (w_state_nxt == StRelease) begin
            w_din_nxt  = 1'b0;
            w_dout_nxt = 1'b0;
            w_sel1_nxt = 1'b0;
            w_sel2_nxt = 1'b0;
            w_wtbt_nxt = 1'b0;
            w_ad_nxt   = '0;
          end
        end
        StRelease: begin
          // After a timeout there is no RPLY to wait out.
          if (r_errp || !rply_i) begin
            w_sync_nxt  = 1'b0;
            w_errp_nxt  = 1'b0;
            w_state_nxt = StIdle;
          end
        end
        StGrant: begin
          if (sack_i) begin
            w_state_nxt = StDma;
            w_dmgo_nxt  = 1'b0;
          end else if (!dmr_i) begin
            w_state_nxt = StIdle;
            w_dmgo_nxt  = 1'b0;
          end
        end
        StDma: begin
          if (!sack_i) w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  assign rdata_o = r_rdata;
  assign done_o  = r_done;
  assign err_o   = r_err;
  assign busy_o  = (r_state != StIdle);
  assign ad_o    = r_ad;
  assign sync_o  = r_sync;
  assign din_o   = r_din;
  assign dout_o  = r_dout;
  assign wtbt_o  = r_wtbt;
  assign bsy_o   = r_sync;
  assign sel1_o  = r_sel1;
  assign sel2_o  = r_sel2;
  assign dmgo_o  = r_dmgo;

endmodule

// File: tb/tb_vm1_qbus_master.sv
// Bench for vm1_qbus_master: directed bus cycles, responses checked by a
// scoreboard monitor that pops an expectation on every done/err pulse.
module tb_vm1_qbus_master;

  logic        clk = 1'b0;
  logic        reset_n, ce, req_i, we_i, byte_i, rply_i, dmr_i, sack_i;
  logic [15:0] addr_i, wdata_i, ad_i;
  logic [15:0] rdata_o, ad_o;
  logic        done_o, err_o, busy_o, sync_o, din_o, dout_o, wtbt_o, bsy_o;
  logic        sel1_o, sel2_o, dmgo_o;

  vm1_qbus_master dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .req_i   (req_i),
    .we_i    (we_i),
    .byte_i  (byte_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .busy_o  (busy_o),
    .ad_o    (ad_o),
    .ad_i    (ad_i),
    .sync_o  (sync_o),
    .din_o   (din_o),
    .dout_o  (dout_o),
    .wtbt_o  (wtbt_o),
    .rply_i  (rply_i),
    .bsy_o   (bsy_o),
    .sel1_o  (sel1_o),
    .sel2_o  (sel2_o),
    .dmr_i   (dmr_i),
    .dmgo_o  (dmgo_o),
    .sack_i  (sack_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        err;
    logic        chk_rd;
    logic [15:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Observations of the most recent cycle (tick indices from request).
  int          t_sync, t_din, t_end, t_off;
  logic        sel1_seen, sel2_seen, dout_seen;
  logic [15:0] adr_ad, dat_ad;
  logic        adr_wt, dat_wt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (done_o === 1'b1 || err_o === 1'b1)) begin
      chk("pulse_exclusive", {31'b0, done_o & err_o}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", sb.size(), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_err", {31'b0, err_o}, {31'b0, mon_e.err});
        if (mon_e.chk_rd) chk("resp_rdata", {16'b0, rdata_o}, {16'b0, mon_e.rd});
      end
    end
  end

  task automatic start_cycle(input logic [15:0] a, input logic w, input logic b,
                             input logic [15:0] wd, input logic [15:0] bus_rd,
                             input logic e_err, input logic e_chk, input logic [15:0] e_rd);
    sb.push_back('{err: e_err, chk_rd: e_chk, rd: e_rd});
    addr_i  = a;
    we_i    = w;
    byte_i  = b;
    wdata_i = wd;
    ad_i    = bus_rd;
    req_i   = 1'b1;
  endtask

  // Acts as the slave: raises RPLY once the data strobe has been seen rdly
  // ticks (never if rdly < 0), then releases the request after the pulse.
  task automatic finish_cycle(input int rdly);
    int ndin;
    ndin = 0;
    t_sync = -1; t_din = -1; t_end = -1; t_off = -1;
    sel1_seen = 1'b0; sel2_seen = 1'b0; dout_seen = 1'b0;
    adr_ad = '0; dat_ad = '0; adr_wt = 1'b0; dat_wt = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (sync_o && t_sync < 0) begin
        t_sync = i; adr_ad = ad_o; adr_wt = wtbt_o;
      end
      if (din_o || dout_o) begin
        if (t_din < 0) begin
          t_din = i; dat_ad = ad_o; dat_wt = wtbt_o; dout_seen = dout_o;
        end
        ndin++;
        if (ndin == rdly) rply_i = 1'b1;
      end
      sel1_seen |= sel1_o;
      sel2_seen |= sel2_o;
      if (done_o || err_o) begin
        t_end = i;
        break;
      end
    end
    chk("cycle_completed", {31'b0, t_end > 0}, 32'd1);
    req_i  = 1'b0;
    rply_i = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (!sync_o && t_off < 0) t_off = t_end + j;
      if (!busy_o) break;
    end
    tick();
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b1; req_i = 1'b0; we_i = 1'b0; byte_i = 1'b0;
    addr_i = '0; wdata_i = '0; ad_i = '0; rply_i = 1'b0; dmr_i = 1'b0; sack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {21'b0, sync_o, din_o, dout_o, wtbt_o, busy_o, bsy_o, sel1_o, sel2_o,
                       dmgo_o, done_o, err_o}, 32'd0);
    chk("reset_ad", {16'b0, ad_o}, 32'd0);
    chk("reset_rdata", {16'b0, rdata_o}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Word read, reply three ticks into the data phase.
    start_cycle(16'o100000, 1'b0, 1'b0, 16'h0, 16'h1234, 1'b0, 1'b1, 16'h1234);
    finish_cycle(3);
    chk("rd_sync_to_din", t_din - t_sync, 32'd1);
    chk("rd_reply_lat", t_end - t_din, 32'd3);
    chk("rd_addr_ad", {16'b0, adr_ad}, 32'o100000);
    chk("rd_addr_wtbt", {31'b0, adr_wt}, 32'd0);
    chk("rd_sync_drop", t_off - t_end, 32'd1);

    // Byte write to an odd address.
    start_cycle(16'o100001, 1'b1, 1'b1, 16'h00A5, 16'h0, 1'b0, 1'b0, 16'h0);
    finish_cycle(2);
    chk("bw_addr_wtbt", {31'b0, adr_wt}, 32'd1);
    chk("bw_data_wtbt", {31'b0, dat_wt}, 32'd1);
    chk("bw_addr_ad", {16'b0, adr_ad}, 32'o100001);
    chk("bw_data_ad", {16'b0, dat_ad}, 32'h00A5);
    chk("bw_dout", {31'b0, dout_seen}, 32'd1);
    chk("bw_reply_lat", t_end - t_din, 32'd2);

    // SEL1 window: completes without RPLY.
    start_cycle(16'o177716, 1'b0, 1'b0, 16'h0, 16'h5A5A, 1'b0, 1'b1, 16'h5A5A);
    finish_cycle(-1);
    chk("sel1_seen", {31'b0, sel1_seen}, 32'd1);
    chk("sel1_no_sel2", {31'b0, sel2_seen}, 32'd0);
    chk("sel1_lat", t_end - t_din, 32'd2);

    // SEL2 window via byte read at odd address (bit 0 ignored).
    start_cycle(16'o177715, 1'b0, 1'b1, 16'h0, 16'h00C3, 1'b0, 1'b1, 16'h00C3);
    finish_cycle(-1);
    chk("sel2_seen", {31'b0, sel2_seen}, 32'd1);
    chk("sel2_no_sel1", {31'b0, sel1_seen}, 32'd0);

    // No reply: timeout error 64 ticks after DIN.
    start_cycle(16'o100200, 1'b0, 1'b0, 16'h0, 16'hFFFF, 1'b1, 1'b0, 16'h0);
    finish_cycle(-1);
    chk("to_lat", t_end - t_din, 32'd64);
    chk("to_sync_drop", t_off - t_end, 32'd1);

    // Odd-address word read: immediate error, no bus cycle.
    start_cycle(16'o100001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0);
    finish_cycle(-1);
    chk("odd_lat", t_end, 32'd1);
    chk("odd_no_sync", t_sync, 32'hFFFF_FFFF);

    // DMA request wins over a simultaneous read; read follows afterwards.
    start_cycle(16'o100000, 1'b0, 1'b0, 16'h0, 16'hBEEF, 1'b0, 1'b1, 16'hBEEF);
    dmr_i = 1'b1;
    tick();
    chk("dma_dmgo", {31'b0, dmgo_o}, 32'd1);
    chk("dma_no_sync", {31'b0, sync_o}, 32'd0);
    sack_i = 1'b1;
    tick();
    chk("dma_dmgo_off", {31'b0, dmgo_o}, 32'd0);
    chk("dma_busy", {31'b0, busy_o}, 32'd1);
    repeat (2) tick();
    chk("dma_bus_quiet", {29'b0, sync_o, din_o, dout_o}, 32'd0);
    dmr_i  = 1'b0;
    sack_i = 1'b0;
    finish_cycle(1);
    chk("dma_then_read", t_end - t_din, 32'd1);

    // DMA request withdrawn before acknowledge.
    dmr_i = 1'b1;
    tick();
    chk("dmr_drop_dmgo", {31'b0, dmgo_o}, 32'd1);
    dmr_i = 1'b0;
    tick();
    chk("dmr_drop_idle", {30'b0, dmgo_o, busy_o}, 32'd0);

    // Clock enable low freezes the sequencer.
    ce = 1'b0;
    start_cycle(16'o100400, 1'b0, 1'b0, 16'h0, 16'h0F0F, 1'b0, 1'b1, 16'h0F0F);
    repeat (3) tick();
    chk("ce_hold", {30'b0, sync_o, busy_o}, 32'd0);
    ce = 1'b1;
    finish_cycle(1);

    // Asynchronous reset in the middle of the data phase.
    addr_i = 16'o100000; we_i = 1'b0; byte_i = 1'b0; req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (din_o) break;
    end
    chk("mid_reset_in_data", {31'b0, din_o}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_reset_ctrl", {21'b0, sync_o, din_o, dout_o, wtbt_o, busy_o, bsy_o, sel1_o, sel2_o,
                           dmgo_o, done_o, err_o}, 32'd0);
    chk("mid_reset_data", {ad_o, rdata_o}, 32'd0);
    req_i = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
